// File: rtl/regfile_scoreboard_if.sv
// Core-monitor bus for the register-file scoreboard: the write-back stream
// observed from the core plus the expected-value table lookup.
interface regfile_scoreboard_if #(
   parameter int XLEN = 32,
   parameter int IW   = 5
);
   logic [31:0]     instr;
   logic            wb_en;
   logic [IW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [IW-1:0]   exp_idx;
   logic [XLEN-1:0] exp_data;
   logic            exp_check;

   // Core/table side: drives the write-back stream and answers table lookups.
   modport master (
      output instr, wb_en, wb_rd, wb_data, exp_data, exp_check,
      input  exp_idx
   );

   // Scoreboard side: observes the write-back stream and walks the table.
   modport slave (
      input  instr, wb_en, wb_rd, wb_data, exp_data, exp_check,
      output exp_idx
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: shadows the core's architectural register writes
// during a run, detects end of program (halt) or a cycle-limit timeout, then
// walks the expected-value table one index per cycle and reports the verdict.
module regfile_scoreboard #(
   parameter int          XLEN       = 32,
   parameter int          NREGS      = 32,
   parameter int          CYC_W      = 16,
   parameter logic [31:0] HALT_INSTR = 32'h0000006F,
   parameter int          MIN_CYCLES = 5,
   localparam int         IW         = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CYC_W-1:0]     max_cycles,
   regfile_scoreboard_if.slave  bus,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic [IW:0]          check_count,
   output logic [IW:0]          pass_count,
   output logic [IW-1:0]        first_fail,
   output logic                 first_fail_valid,
   output logic [CYC_W-1:0]     cycles
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMPARE, S_DONE} state_t;

   localparam logic [CYC_W-1:0] MIN_CYC  = CYC_W'(MIN_CYCLES);
   localparam logic [IW-1:0]    LAST_IDX = IW'(NREGS - 1);

   state_t            state_q;
   logic [XLEN-1:0]   shadow_q [NREGS];
   logic [CYC_W-1:0]  cycles_q, max_q;
   logic [IW-1:0]     idx_q, first_fail_q;
   logic [IW:0]       check_q, pass_cnt_q;
   logic              busy_q, done_q, pass_q, timeout_q, ffv_q;

   logic [CYC_W:0]    cycles_plus;
   logic [CYC_W-1:0]  cycles_d;
   logic              halt_hit, limit_hit;
   logic [XLEN-1:0]   shadow_rd;
   logic              entry_match;
   logic [IW:0]       check_d, pass_cnt_d;

   // Next-state helpers: halt/limit detection, saturating cycle count, compare step.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; an unassigned path would infer a latch.
   always_comb begin
      cycles_plus = {1'b0, cycles_q} + (CYC_W+1)'(1);
      cycles_d    = (cycles_q == '1) ? cycles_q : cycles_plus[CYC_W-1:0];
      halt_hit    = (bus.instr == HALT_INSTR) && (cycles_q >= MIN_CYC);
      limit_hit   = (max_q != '0) && (cycles_plus == {1'b0, max_q});
      shadow_rd   = (idx_q == '0) ? '0 : shadow_q[idx_q];
      entry_match = (shadow_rd == bus.exp_data);
      check_d     = check_q;
      pass_cnt_d  = pass_cnt_q;
      if (bus.exp_check) begin
         check_d = check_q + (IW+1)'(1);
         if (entry_match) pass_cnt_d = pass_cnt_q + (IW+1)'(1);
      end
   end

   // Main FSM with registered outputs, shadow file and result counters.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cycles_q     <= '0;
         max_q        <= '0;
         idx_q        <= '0;
         first_fail_q <= '0;
         check_q      <= '0;
         pass_cnt_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         ffv_q        <= 1'b0;
         // NOTE: the shadow file is architectural state that must read zero
         // after reset, so it is built from resettable flops, not a RAM.
         for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
                  state_q      <= S_RUN;
                  cycles_q     <= '0;
                  max_q        <= max_cycles;
                  idx_q        <= '0;
                  first_fail_q <= '0;
                  check_q      <= '0;
                  pass_cnt_q   <= '0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  timeout_q    <= 1'b0;
                  ffv_q        <= 1'b0;
               end
            end
            S_RUN: begin
               cycles_q <= cycles_d;
               // x0 is hard-wired zero, so writes to it never reach the shadow.
               if (bus.wb_en && (bus.wb_rd != '0)) shadow_q[bus.wb_rd] <= bus.wb_data;
               if (halt_hit) begin
                  state_q   <= S_COMPARE;
                  timeout_q <= 1'b0;
               end else if (limit_hit) begin
                  state_q   <= S_COMPARE;
                  timeout_q <= 1'b1;
               end
            end
            S_COMPARE: begin
               check_q    <= check_d;
               pass_cnt_q <= pass_cnt_d;
               if (bus.exp_check && !entry_match && !ffv_q) begin
                  first_fail_q <= idx_q;
                  ffv_q        <= 1'b1;
               end
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (check_d == pass_cnt_d) && !timeout_q;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.exp_idx       = idx_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign pass              = pass_q;
   assign timeout           = timeout_q;
   assign check_count       = check_q;
   assign pass_count        = pass_cnt_q;
   assign first_fail        = first_fail_q;
   assign first_fail_valid  = ffv_q;
   assign cycles            = cycles_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: drives short programs through the
// write-back bus, serves the expected table, and checks hand-computed results.
module tb_regfile_scoreboard;
   localparam int          XLEN  = 32;
   localparam int          NREGS = 32;
   localparam int          CYC_W = 16;
   localparam int          IW    = 5;
   localparam logic [31:0] HALT  = 32'h0000006F;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic             clk = 1'b0;
   logic             reset, start;
   logic [CYC_W-1:0] max_cycles;
   logic             busy, done, pass, timeout, first_fail_valid;
   logic [IW:0]      check_count, pass_count;
   logic [IW-1:0]    first_fail;
   logic [CYC_W-1:0] cycles;

   logic [XLEN-1:0]  exp_tab [NREGS];
   logic             chk_tab [NREGS];
   int               n_tests = 0;
   int               n_fail  = 0;
   int               lat;

   regfile_scoreboard_if #(.XLEN(XLEN), .IW(IW)) bus ();

   regfile_scoreboard #(
      .XLEN(XLEN), .NREGS(NREGS), .CYC_W(CYC_W),
      .HALT_INSTR(HALT), .MIN_CYCLES(5)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .max_cycles(max_cycles),
      .bus(bus), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .check_count(check_count), .pass_count(pass_count),
      .first_fail(first_fail), .first_fail_valid(first_fail_valid),
      .cycles(cycles)
   );

   always #5 clk = ~clk;

   // Zero-latency expected table served from the bench arrays.
   assign bus.exp_data  = exp_tab[bus.exp_idx];
   assign bus.exp_check = chk_tab[bus.exp_idx];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [31:0] ins, input logic en,
                       input logic [IW-1:0] rd, input logic [XLEN-1:0] d);
      bus.instr = ins; bus.wb_en = en; bus.wb_rd = rd; bus.wb_data = d;
      tick();
      bus.instr = NOP; bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) step(NOP, 1'b0, '0, '0);
   endtask

   task automatic begin_run(input logic [CYC_W-1:0] mc);
      start = 1'b1; max_cycles = mc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 1000) begin
         tick();
         n++;
      end
      check("done_reached", {31'b0, done}, 32'd1);
   endtask

   task automatic clear_table();
      for (int i = 0; i < NREGS; i++) begin
         exp_tab[i] = '0;
         chk_tab[i] = 1'b0;
      end
   endtask

   // Program: x1=5, x2=7, x3=12 at cycles 1..3, HALT at cycle 8, limit 50.
   task automatic run_prog_a(output int n);
      begin_run(16'd50);
      check("a_busy_run", {31'b0, busy}, 32'd1);
      check("a_cycles_start", {16'b0, cycles}, 32'd0);
      step(NOP, 1'b0, 5'd0, 32'd0);
      step(NOP, 1'b1, 5'd1, 32'd5);
      step(NOP, 1'b1, 5'd2, 32'd7);
      step(NOP, 1'b1, 5'd3, 32'd12);
      nops(4);
      step(HALT, 1'b0, 5'd0, 32'd0);
      check("a_busy_cmp", {31'b0, busy}, 32'd1);
      check("a_done_cmp", {31'b0, done}, 32'd0);
      check("a_idx0", {27'b0, bus.exp_idx}, 32'd0);
      check("a_cycles", {16'b0, cycles}, 32'd9);
      tick();
      check("a_idx1", {27'b0, bus.exp_idx}, 32'd1);
      wait_done(n);
      n = n + 1;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; max_cycles = '0;
      bus.instr = NOP; bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      clear_table();
      tick();
      // start while in reset must be ignored
      start = 1'b1; max_cycles = 16'd7;
      tick();
      start = 1'b0;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_pass", {31'b0, pass}, 32'd0);
      check("rst_timeout", {31'b0, timeout}, 32'd0);
      check("rst_check_count", {26'b0, check_count}, 32'd0);
      check("rst_pass_count", {26'b0, pass_count}, 32'd0);
      check("rst_ffv", {31'b0, first_fail_valid}, 32'd0);
      check("rst_cycles", {16'b0, cycles}, 32'd0);
      check("rst_exp_idx", {27'b0, bus.exp_idx}, 32'd0);
      reset = 1'b1;
      tick();
      check("rst_start_ignored", {31'b0, busy}, 32'd0);

      // All checked entries match.
      exp_tab[1] = 32'd5; exp_tab[2] = 32'd7; exp_tab[3] = 32'd12;
      chk_tab[1] = 1'b1;  chk_tab[2] = 1'b1;  chk_tab[3] = 1'b1;
      run_prog_a(lat);
      check("a_latency", lat, NREGS);
      check("a_pass", {31'b0, pass}, 32'd1);
      check("a_check_count", {26'b0, check_count}, 32'd3);
      check("a_pass_count", {26'b0, pass_count}, 32'd3);
      check("a_ffv", {31'b0, first_fail_valid}, 32'd0);
      check("a_timeout", {31'b0, timeout}, 32'd0);
      check("a_busy_done", {31'b0, busy}, 32'd0);
      check("a_idx_done", {27'b0, bus.exp_idx}, 32'd0);
      step(NOP, 1'b1, 5'd1, 32'd99);
      nops(2);
      check("a_hold_done", {31'b0, done}, 32'd1);
      check("a_hold_pass", {31'b0, pass}, 32'd1);
      check("a_hold_count", {26'b0, check_count}, 32'd3);

      // Same program, x3 expected 13: mismatch at index 3.
      exp_tab[3] = 32'd13;
      run_prog_a(lat);
      check("b_pass", {31'b0, pass}, 32'd0);
      check("b_first_fail", {27'b0, first_fail}, 32'd3);
      check("b_ffv", {31'b0, first_fail_valid}, 32'd1);
      check("b_pass_count", {26'b0, pass_count}, 32'd2);
      check("b_check_count", {26'b0, check_count}, 32'd3);

      // Early HALT rejected (cycle 2 < 5), run ends by the 20-cycle limit.
      clear_table();
      begin_run(16'd20);
      nops(2);
      step(HALT, 1'b0, 5'd0, 32'd0);
      wait_done(lat);
      check("c_latency", lat, 32'd49);
      check("c_timeout", {31'b0, timeout}, 32'd1);
      check("c_cycles", {16'b0, cycles}, 32'd20);
      check("c_pass", {31'b0, pass}, 32'd0);
      check("c_check_count", {26'b0, check_count}, 32'd0);

      // x0 write discarded; HALT at cycle 4 rejected, at cycle 5 accepted.
      clear_table();
      chk_tab[0] = 1'b1;
      begin_run(16'd0);
      step(NOP, 1'b0, 5'd0, 32'd0);
      step(NOP, 1'b1, 5'd0, 32'hDEADBEEF);
      nops(2);
      step(HALT, 1'b0, 5'd0, 32'd0);
      step(HALT, 1'b0, 5'd0, 32'd0);
      wait_done(lat);
      check("d_cycles", {16'b0, cycles}, 32'd6);
      check("d_pass", {31'b0, pass}, 32'd1);
      check("d_check_count", {26'b0, check_count}, 32'd1);
      check("d_pass_count", {26'b0, pass_count}, 32'd1);
      check("d_timeout", {31'b0, timeout}, 32'd0);

      // HALT on the limit cycle with a write to x4: halt wins, write commits.
      clear_table();
      exp_tab[4] = 32'd9; chk_tab[4] = 1'b1;
      begin_run(16'd10);
      nops(9);
      step(HALT, 1'b1, 5'd4, 32'd9);
      wait_done(lat);
      check("e_timeout", {31'b0, timeout}, 32'd0);
      check("e_cycles", {16'b0, cycles}, 32'd10);
      check("e_pass", {31'b0, pass}, 32'd1);
      check("e_pass_count", {26'b0, pass_count}, 32'd1);

      // Reset mid-COMPARE, then an independent second run.
      clear_table();
      exp_tab[1] = 32'd5; exp_tab[2] = 32'd7; exp_tab[3] = 32'd13;
      chk_tab[1] = 1'b1;  chk_tab[2] = 1'b1;  chk_tab[3] = 1'b1;
      begin_run(16'd0);
      step(NOP, 1'b0, 5'd0, 32'd0);
      step(NOP, 1'b1, 5'd1, 32'd5);
      step(NOP, 1'b1, 5'd2, 32'd7);
      step(NOP, 1'b1, 5'd3, 32'd12);
      step(NOP, 1'b0, 5'd0, 32'd0);
      step(HALT, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 10; i++) tick();
      check("f_mid_check_count", {26'b0, check_count}, 32'd3);
      check("f_mid_ffv", {31'b0, first_fail_valid}, 32'd1);
      reset = 1'b0; start = 1'b1;
      tick();
      reset = 1'b1; start = 1'b0;
      check("f_rst_busy", {31'b0, busy}, 32'd0);
      check("f_rst_check_count", {26'b0, check_count}, 32'd0);
      check("f_rst_pass_count", {26'b0, pass_count}, 32'd0);
      check("f_rst_ffv", {31'b0, first_fail_valid}, 32'd0);
      check("f_rst_cycles", {16'b0, cycles}, 32'd0);
      check("f_rst_exp_idx", {27'b0, bus.exp_idx}, 32'd0);
      tick();
      check("f_idle_after_rst", {31'b0, busy}, 32'd0);
      exp_tab[1] = 32'd0; exp_tab[2] = 32'd0; exp_tab[3] = 32'd0;
      begin_run(16'd0);
      nops(5);
      step(HALT, 1'b0, 5'd0, 32'd0);
      wait_done(lat);
      check("f2_pass", {31'b0, pass}, 32'd1);
      check("f2_check_count", {26'b0, check_count}, 32'd3);
      check("f2_pass_count", {26'b0, pass_count}, 32'd3);
      check("f2_ffv", {31'b0, first_fail_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, 32, register data width.
REQ-002 Parameter NREGS, 32, number of architectural registers tracked; power of two, IW = log2(NREGS).
REQ-003 Parameter CYC_W, 16, cycle-counter width.
REQ-004 Parameter HALT_INSTR, 32'h0000006F, end-of-program instruction encoding (jal x0, 0).
REQ-005 Parameter MIN_CYCLES, 5, RUN cycles that must elapse before a halt is accepted.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  single-cycle pulse; begins a new run when in IDLE or DONE.
REQ-009 max_cycles  in  CYC_W  timeout limit, sampled on accepted start; 0 = no timeout.
REQ-010 instr  in  32  instruction currently being executed by the DUT core.
REQ-011 wb_en  in  1  register-file write enable of the DUT core.
REQ-012 wb_rd  in  IW  destination register index.
REQ-013 wb_data  in  XLEN  write-back data.
REQ-014 exp_idx  out  IW  index into the expected-value table.
REQ-015 exp_data  in  XLEN  expected value for exp_idx, combinational (zero-latency) table.
REQ-016 exp_check  in  1  1 = entry at exp_idx is checked, 0 = don't-care.
REQ-017 busy  out  1  high in RUN and COMPARE.
REQ-018 done  out  1  high in DONE.
REQ-019 pass  out  1  valid when done; all checks matched and no timeout.
REQ-020 timeout  out  1  run ended by max_cycles, not by halt.
REQ-021 check_count, pass_count  out  IW+1 each  checked / matching entries.
REQ-022 first_fail  out  IW  lowest mismatching index; first_fail_valid  out  1.
REQ-023 cycles  out  CYC_W  RUN cycles elapsed in the last/current run.

Function
REQ-024 FSM states IDLE, RUN, COMPARE, DONE; start ignored in RUN and COMPARE.
REQ-025 IDLE/DONE + start: clear shadow file, cycles, counts, timeout, first_fail_valid; latch max_cycles; next state RUN.
REQ-026 RUN: cycles increments by 1 every cycle, saturating at all-ones.
REQ-027 RUN: wb_en=1 and wb_rd!=0 writes wb_data into shadow[wb_rd] at the edge; writes to index 0 discarded; shadow[0] reads 0.
REQ-028 RUN: halt when instr==HALT_INSTR and cycles>=MIN_CYCLES; next state COMPARE, timeout=0.
REQ-029 RUN: max_cycles!=0 and cycles+1==max_cycles at the edge (run reached max_cycles cycles): next state COMPARE, timeout=1.
REQ-030 Halt and timeout in the same cycle: halt wins, timeout=0.
REQ-031 Write-back present in the halt/timeout cycle is committed to the shadow file.
REQ-032 wb_en ignored outside RUN.
REQ-033 COMPARE: exp_idx steps 0..NREGS-1, one index per cycle, exactly NREGS cycles; exp_idx=0 outside COMPARE.
REQ-034 Per index with exp_check=1: check_count+1; shadow==exp_data -> pass_count+1, else record index in first_fail if first_fail_valid=0, then set first_fail_valid.
REQ-035 After index NREGS-1 -> DONE; done=1; pass=(check_count==pass_count)&&!timeout; zero checks with no timeout -> pass=1.
REQ-036 DONE holds all result outputs stable until next accepted start.
REQ-037 Total latency halt-detect to done: NREGS+1 cycles.

Reset
REQ-038 reset=0 at a rising edge forces IDLE regardless of state, including mid-RUN/COMPARE.
REQ-039 Reset values: busy=0, done=0, pass=0, timeout=0, counts=0, first_fail=0, first_fail_valid=0, cycles=0, exp_idx=0, shadow file all zero.
REQ-040 start sampled while reset=0 is ignored.

Verification
REQ-041 start, max_cycles=50; writes x1=5, x2=7, x3=12; HALT at cycle 8; table checks x1..x3 = 5,7,12 -> done after NREGS+1 cycles, pass=1, check_count=3, pass_count=3.
REQ-042 Same run, table expects x3=13 -> pass=0, first_fail=3, first_fail_valid=1, pass_count=2.
REQ-043 HALT_INSTR at cycle 2 then never again, max_cycles=20 -> halt rejected, timeout=1, cycles=20, pass=0.
REQ-044 wb_rd=0 with wb_data=32'hDEADBEEF, table expects x0=0 -> x0 check passes.
REQ-045 HALT and cycles+1==max_cycles same cycle, with write x4=9 -> timeout=0, x4 check sees 9.
REQ-046 reset=0 mid-COMPARE, then start -> counts restart at 0, shadow cleared, second run independent of first.
